pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage core. It turns per-stage stall requests into the 6-bit stall vector consumed by the PC and by every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB). It also turns MEM-stage exceptions into a flush pulse and a redirect PC. It tracks stall episodes with an FSM, a consecutive-stall watchdog and a cause register, and optionally with performance counters.

Parameters:
MAX_STALL, 64, consecutive stall cycles before the watchdog flags a hang (2..65535)
EXC_VECTOR, 32'h00000020, redirect PC for all exceptions except ERET
ERET_CODE, 32'h0000000e, except_type value meaning ERET (redirect to epc)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
stallreq_if  in  1  fetch bus wait
stallreq_id  in  1  load-use hazard
stallreq_ex  in  1  multi-cycle EX op (madd/msub/div)
stallreq_mem  in  1  data bus wait
except_valid  in  1  MEM stage reports an exception this cycle
except_type  in  32  exception code from MEM
cp0_epc  in  32  current EPC
stall  out  6  bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = hold
flush  out  1  clear all pipeline registers this cycle
new_pc  out  32  redirect target, valid when flush=1
stall_cause  out  3  registered: 0 none, 1 IF, 2 ID, 3 EX, 4 MEM
wd_timeout  out  1  sticky watchdog flag
wd_clr  in  1  clears wd_timeout

Behaviour:
- stall, flush and new_pc are combinational, with the same-cycle effect the pipeline registers need.
- Priority: except_valid > mem > ex > id > if.
  - except_valid=1: flush=1, stall=6'b000000, new_pc = (except_type==ERET_CODE) ? cp0_epc : EXC_VECTOR.
  - Else stallreq_mem: stall=6'b011111.
  - Else stallreq_ex: stall=6'b001111.
  - Else stallreq_id: stall=6'b000111.
  - Else stallreq_if: stall=6'b000011.
  - Else stall=0.
  - flush=0 and new_pc=0 whenever except_valid=0.
- Downstream rule: the lowest stalled stage with the next stage running inserts a bubble.
- FSM states: RUN, STALL, FLUSH (registered, updated at posedge).
  - RUN -> STALL when stall!=0. RUN -> FLUSH when flush=1.
  - STALL -> RUN when stall==0 and flush=0. STALL -> FLUSH when flush=1.
  - FLUSH -> RUN unconditionally after 1 cycle. During FLUSH, stallreq_* are honoured normally; a new except_valid re-flushes (stays in FLUSH).
- stall_cause is registered each cycle with the winning source (0 when none or when flushing). It shows the previous cycle's cause.
- Watchdog counter (16 bits):
  - Increments each cycle stall!=0; cleared when stall==0 or flush=1; saturates at MAX_STALL.
  - When the counter reaches MAX_STALL: wd_timeout<=1, and it stays 1 until wd_clr or rst.
  - wd_clr in the same cycle as a new timeout: the set wins.
  - The watchdog never overrides the stall vector.
- Reset: state=RUN, counter=0, stall_cause=0, wd_timeout=0. Combinational outputs follow their inputs. Reset mid-stall drops all state at the next edge.

Optional Feature:
PIPE_CTRL_PERF_EN: adds outputs perf_stall_cycles[31:0], perf_flushes[15:0] and input perf_clr.
- perf_stall_cycles counts cycles with stall!=0; perf_flushes counts flush cycles.
- Both saturate, and are zeroed by rst or perf_clr.
- Without the macro: no ports, no counters, identical remaining behaviour.

Decomposition:
- Shared defines header: Stop/NoStop, stall vector constants (STALL_NONE, STALL_FROM_IF/ID/EX/MEM), cause codes, FSM state encodings, EXC/ERET constants.
- One natural sub-module: pipe_ctrl_wdog (saturating counter plus sticky flag), instantiated once.

Test Plan:
- Reset held 3 cycles with all requests high -> after release stall=6'b011111, stall_cause=4 one cycle later, wd_timeout=0.
- stallreq_id=1 for 2 cycles, then 0 -> stall=6'b000111 for 2 cycles then 0; FSM RUN->STALL->RUN; stall_cause 2,2,0.
- stallreq_ex and stallreq_id together -> stall=6'b001111; adding stallreq_mem -> 6'b011111.
- except_valid=1, except_type=0x0e, cp0_epc=0x80001000, with stallreq_mem=1 -> flush=1, stall=0, new_pc=0x80001000; type 0x08 -> new_pc=0x00000020.
- MAX_STALL=4, stallreq_if held 6 cycles -> wd_timeout rises after the 4th stalled cycle and stays 1 after the request drops; wd_clr pulse -> 0.
- With PIPE_CTRL_PERF_EN: 3 stalled cycles plus 2 flush cycles -> perf_stall_cycles=3, perf_flushes=2; perf_clr -> both 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, enums and the stall-priority decoder for the pipeline controller.
package pipe_ctrl_pkg;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // Stall vectors: bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
  localparam logic [5:0] STALL_NONE     = 6'b000000;
  localparam logic [5:0] STALL_FROM_IF  = 6'b000011;
  localparam logic [5:0] STALL_FROM_ID  = 6'b000111;
  localparam logic [5:0] STALL_FROM_EX  = 6'b001111;
  localparam logic [5:0] STALL_FROM_MEM = 6'b011111;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;
  localparam logic [31:0] ERET_CODE_DEF  = 32'h0000_000e;

  typedef enum logic [2:0] {
    CAUSE_NONE = 3'd0,
    CAUSE_IF   = 3'd1,
    CAUSE_ID   = 3'd2,
    CAUSE_EX   = 3'd3,
    CAUSE_MEM  = 3'd4
  } cause_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic [5:0] stall;
    cause_e     cause;
  } stall_dec_t;

  // An exception suppresses every stall: the flush already clears the pipe.
  function automatic stall_dec_t decode_stall(input logic exc, input logic req_mem,
                                              input logic req_ex, input logic req_id,
                                              input logic req_if);
    stall_dec_t d;
    d.stall = STALL_NONE;
    d.cause = CAUSE_NONE;
    if (exc) begin
      d.stall = STALL_NONE;
      d.cause = CAUSE_NONE;
    end else if (req_mem) begin
      d.stall = STALL_FROM_MEM;
      d.cause = CAUSE_MEM;
    end else if (req_ex) begin
      d.stall = STALL_FROM_EX;
      d.cause = CAUSE_EX;
    end else if (req_id) begin
      d.stall = STALL_FROM_ID;
      d.cause = CAUSE_ID;
    end else if (req_if) begin
      d.stall = STALL_FROM_IF;
      d.cause = CAUSE_IF;
    end
    return d;
  endfunction

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// Consecutive-stall watchdog: saturating counter plus a sticky timeout flag.
module pipe_ctrl_wdog
  import pipe_ctrl_pkg::*;
#(
  parameter logic [15:0] MAX = 16'd64
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  input  logic wd_clr_i,
  output logic wd_timeout_o
);

  logic [15:0] cnt_q, cnt_d;
  logic        to_q, to_d;
  logic        hit;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !inc_i)  cnt_d = '0;
    else if (cnt_q != MAX) cnt_d = cnt_q + 16'd1;
    hit = (cnt_d == MAX);
    // A fresh timeout beats a simultaneous clear.
    to_d = to_q;
    if (hit)           to_d = 1'b1;
    else if (wd_clr_i) to_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign wd_timeout_o = to_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall vector, exception flush/redirect, stall FSM, cause and watchdog.
// Define PIPE_CTRL_PERF_EN to add saturating stall-cycle and flush performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          MAX_STALL  = 64,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter logic [31:0] ERET_CODE  = ERET_CODE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        except_valid,
  input  logic [31:0] except_type,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [2:0]  stall_cause,
  output logic        wd_timeout,
  input  logic        wd_clr
`ifdef PIPE_CTRL_PERF_EN
  ,
  input  logic        perf_clr,
  output logic [31:0] perf_stall_cycles,
  output logic [15:0] perf_flushes
`endif
);

  localparam logic [15:0] MAX16 = 16'(MAX_STALL);

  stall_dec_t dec;
  state_e     state_q, state_d;
  cause_e     cause_q, cause_d;
  logic       stalling;

  always_comb begin
    dec      = decode_stall(except_valid, stallreq_mem, stallreq_ex, stallreq_id, stallreq_if);
    stalling = (dec.stall != STALL_NONE);
    stall    = dec.stall;
    flush    = except_valid;
    new_pc   = '0;
    if (except_valid) new_pc = (except_type == ERET_CODE) ? cp0_epc : EXC_VECTOR;
    cause_d  = dec.cause;
  end

  // Flush dominates from every state; FLUSH lasts one cycle unless re-flushed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (flush) state_d = ST_FLUSH; else if (stalling) state_d = ST_STALL;
      ST_STALL: if (flush) state_d = ST_FLUSH; else if (!stalling) state_d = ST_RUN;
      ST_FLUSH: if (flush) state_d = ST_FLUSH; else state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  assign stall_cause = cause_q;

  pipe_ctrl_wdog #(.MAX(MAX16)) u_wdog (
    .clk          (clk),
    .rst          (rst),
    .inc_i        (stalling),
    .clr_i        (flush),
    .wd_clr_i     (wd_clr),
    .wd_timeout_o (wd_timeout)
  );

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] pstall_q, pstall_d;
  logic [15:0] pflush_q, pflush_d;

  always_comb begin
    pstall_d = pstall_q;
    pflush_d = pflush_q;
    if (perf_clr) begin
      pstall_d = '0;
      pflush_d = '0;
    end else begin
      if (stalling && (pstall_q != '1)) pstall_d = pstall_q + 32'd1;
      if (flush && (pflush_q != '1))    pflush_d = pflush_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pstall_q <= '0;
      pflush_q <= '0;
    end else begin
      pstall_q <= pstall_d;
      pflush_q <= pflush_d;
    end
  end

  assign perf_stall_cycles = pstall_q;
  assign perf_flushes      = pflush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a cycle-level reference model and literal spot checks.
module tb_pipe_ctrl;
  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        except_valid;
  logic [31:0] except_type, cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [2:0]  stall_cause;
  logic        wd_timeout;
  logic        wd_clr;
`ifdef PIPE_CTRL_PERF_EN
  logic        perf_clr;
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_flushes;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.MAX_STALL(MAXS)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .except_valid(except_valid), .except_type(except_type), .cp0_epc(cp0_epc),
    .stall(stall), .flush(flush), .new_pc(new_pc), .stall_cause(stall_cause),
    .wd_timeout(wd_timeout), .wd_clr(wd_clr)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_clr(perf_clr), .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes)
`endif
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: priority table, cause, stall-run length and counters as plain integers.
  function automatic logic [5:0] exp_stall();
    if (except_valid) return 6'b000000;
    if (stallreq_mem) return 6'b011111;
    if (stallreq_ex)  return 6'b001111;
    if (stallreq_id)  return 6'b000111;
    if (stallreq_if)  return 6'b000011;
    return 6'b000000;
  endfunction

  function automatic int exp_cause();
    if (except_valid) return 0;
    if (stallreq_mem) return 4;
    if (stallreq_ex)  return 3;
    if (stallreq_id)  return 2;
    if (stallreq_if)  return 1;
    return 0;
  endfunction

  int m_cause = 0, m_run = 0, m_pstall = 0, m_pflush = 0;
  bit m_wd = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_cause = 0; m_run = 0; m_wd = 0; m_pstall = 0; m_pflush = 0;
    end else begin
      m_cause = exp_cause();
      if (exp_stall() == 6'b0) m_run = 0;
      else if (m_run < MAXS)   m_run = m_run + 1;
      if (m_run == MAXS) m_wd = 1;
      else if (wd_clr)   m_wd = 0;
`ifdef PIPE_CTRL_PERF_EN
      if (perf_clr) begin
        m_pstall = 0; m_pflush = 0;
      end else begin
        if (exp_stall() != 6'b0) m_pstall++;
        if (except_valid)        m_pflush++;
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_stall", 32'(stall), 32'(exp_stall()));
      chk("m_flush", 32'(flush), 32'(except_valid));
      chk("m_new_pc", new_pc, !except_valid ? 32'h0 :
          (except_type == 32'h0000000e) ? cp0_epc : 32'h00000020);
      chk("m_cause", 32'(stall_cause), 32'(m_cause));
      chk("m_wd", 32'(wd_timeout), 32'(m_wd));
`ifdef PIPE_CTRL_PERF_EN
      chk("m_pstall", perf_stall_cycles, 32'(m_pstall));
      chk("m_pflush", 32'(perf_flushes), 32'(m_pflush));
`endif
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic clear_reqs();
    stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    except_valid = 0; except_type = '0; cp0_epc = '0;
  endtask

  initial begin
    rst = 1; wd_clr = 0;
`ifdef PIPE_CTRL_PERF_EN
    perf_clr = 0;
`endif
    clear_reqs();
    stallreq_if = 1; stallreq_id = 1; stallreq_ex = 1; stallreq_mem = 1;
    cyc(); chk_en = 1;
    cyc(); cyc();
    rst = 0;
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'h1f);
    chk("rst_cause", 32'(stall_cause), 0);
    chk("rst_wd", 32'(wd_timeout), 0);
    cyc(); @(negedge clk);
    chk("rel_cause", 32'(stall_cause), 4);
    cyc(); clear_reqs(); cyc();

    // load-use for two cycles
    stallreq_id = 1; @(negedge clk);
    chk("id_stall0", 32'(stall), 32'h07);
    cyc(); @(negedge clk);
    chk("id_cause0", 32'(stall_cause), 2);
    cyc(); stallreq_id = 0; @(negedge clk);
    chk("id_stall_off", 32'(stall), 0);
    chk("id_cause1", 32'(stall_cause), 2);
    cyc(); @(negedge clk);
    chk("id_cause2", 32'(stall_cause), 0);

    stallreq_ex = 1; stallreq_id = 1; @(negedge clk);
    chk("exid_stall", 32'(stall), 32'h0f);
    cyc(); stallreq_mem = 1; @(negedge clk);
    chk("mem_stall", 32'(stall), 32'h1f);
    cyc(); clear_reqs(); cyc();

    // exception beats a memory stall
    except_valid = 1; except_type = 32'h0e; cp0_epc = 32'h80001000; stallreq_mem = 1;
    @(negedge clk);
    chk("eret_flush", 32'(flush), 1);
    chk("eret_stall", 32'(stall), 0);
    chk("eret_pc", new_pc, 32'h80001000);
    #1 except_type = 32'h08; #1;
    chk("exc_pc", new_pc, 32'h00000020);
    cyc(); clear_reqs(); @(negedge clk);
    chk("exc_cause", 32'(stall_cause), 0);
    chk("idle_pc", new_pc, 0);
    cyc();

    // watchdog: timeout after the 4th stalled cycle, sticky, then cleared
    stallreq_if = 1;
    cyc(); cyc(); cyc(); @(negedge clk);
    chk("wd_pre", 32'(wd_timeout), 0);
    cyc(); @(negedge clk);
    chk("wd_hit", 32'(wd_timeout), 1);
    cyc(); cyc(); stallreq_if = 0;
    cyc(); cyc(); @(negedge clk);
    chk("wd_sticky", 32'(wd_timeout), 1);
    wd_clr = 1; cyc(); wd_clr = 0; @(negedge clk);
    chk("wd_cleared", 32'(wd_timeout), 0);

    // set wins over a simultaneous clear
    wd_clr = 1; stallreq_if = 1;
    repeat (4) cyc();
    @(negedge clk);
    chk("wd_set_wins", 32'(wd_timeout), 1);
    cyc(); stallreq_if = 0; cyc(); @(negedge clk);
    chk("wd_clr_hold", 32'(wd_timeout), 0);
    wd_clr = 0;

    // a flush restarts the stall-run count
    stallreq_if = 1; repeat (3) cyc();
    except_valid = 1; cyc(); except_valid = 0;
    repeat (3) cyc(); @(negedge clk);
    chk("wd_flush_reset", 32'(wd_timeout), 0);
    clear_reqs(); cyc();

    // reset in the middle of a stall
    stallreq_mem = 1; cyc(); cyc();
    rst = 1; cyc(); rst = 0; stallreq_mem = 0; @(negedge clk);
    chk("midrst_cause", 32'(stall_cause), 0);
    cyc();

`ifdef PIPE_CTRL_PERF_EN
    perf_clr = 1; cyc(); perf_clr = 0;
    stallreq_if = 1; repeat (3) cyc();
    stallreq_if = 0; except_valid = 1; repeat (2) cyc();
    clear_reqs(); @(negedge clk);
    chk("perf_stall", perf_stall_cycles, 3);
    chk("perf_flush", 32'(perf_flushes), 2);
    perf_clr = 1; cyc(); perf_clr = 0; @(negedge clk);
    chk("perf_clr_s", perf_stall_cycles, 0);
    chk("perf_clr_f", 32'(perf_flushes), 0);
`endif

    cyc();
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
